score_scheduler: RTL and testbench
==================================

# score_scheduler

Sequencer that owns the `evaluate` scoring unit for one song. It accepts base/test sample pairs over a valid/ready stream, launches one `evaluate` run per segment, and collects each pass/fail result. It accumulates a hit score and a best-streak (combo) count over `SEG_NUM` segments, then reports completion. It sits between the audio sample path (SRAM base track, recorded test track) and the top-level score display.

## Interface
- `SEG_NUM`, 16: segments (evaluate runs) per song; legal range 1..255.
- `SCORE_W`, 8: width of `o_score`/`o_combo`; must satisfy `SEG_NUM <= 2**SCORE_W-1`.
- `TIMEOUT`, 1024: WAIT-state cycle limit (only with the timeout feature).
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: begin song scoring; sampled in IDLE only.
- `i_abort` in 1: cancel the current song from any state.
- `i_sample_valid` in 1: sample pair available.
- `i_sample_base` in 16: base-track sample.
- `i_sample_test` in 16: test-track sample.
- `o_sample_ready` out 1: scheduler accepts a pair this cycle.
- `o_eval_start` out 1: one-cycle start pulse to `evaluate`.
- `o_eval_base` out 16: registered base sample driven to `evaluate`.
- `o_eval_test` out 16: registered test sample driven to `evaluate`.
- `i_eval_finish` in 1: `evaluate` run complete.
- `i_eval_result` in 1: 1 = hit, valid with `i_eval_finish`.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse when all segments are tallied.
- `o_aborted` out 1: one-cycle pulse when an abort is taken.
- `o_score` out `SCORE_W`: number of hits.
- `o_combo` out `SCORE_W`: longest run of consecutive hits.
- `o_seg_idx` out 8: index of the current segment.
- `o_timeout` out 1: sticky flag, set if any segment timed out.

## Operation
- **States:** IDLE, FETCH, KICK, WAIT, DONE.
- **IDLE:**
  - `i_start`=1 and `i_abort`=0: clear score, combo, running streak, `o_seg_idx` and `o_timeout`; go to FETCH.
- **FETCH:**
  - `o_sample_ready`=1.
  - On `i_sample_valid`: latch both samples into `o_eval_base`/`o_eval_test`; go to KICK.
- **KICK:**
  - `o_eval_start`=1 for exactly this cycle; go to WAIT.
  - `i_eval_finish` in KICK is ignored.
- **WAIT:**
  - `o_eval_base`/`o_eval_test` are held stable.
  - On `i_eval_finish`, the tally updates:
    - Hit: score+1, streak+1, combo=max(combo, streak+1).
    - Miss: streak=0.
  - If `o_seg_idx==SEG_NUM-1`, go to DONE. Otherwise `o_seg_idx`+1 and go to FETCH.
- **DONE:**
  - `o_done`=1 for one cycle; go to IDLE.
  - `o_score`/`o_combo` hold until the next accepted start.
- **Abort:**
  - `i_abort`=1 in FETCH/KICK/WAIT/DONE: go to IDLE next cycle with `o_aborted`=1; no `o_done`.
  - Partial score and combo are retained.
  - `o_eval_start` is not issued if abort arrives in FETCH.
- **Arithmetic:** score and combo saturate at `2**SCORE_W-1`; no wrap.

## Timing
- **Reset:** all outputs 0, state IDLE, internal streak 0.
- **Start to sample ready:** `i_start` at cycle n gives `o_sample_ready`=1 at n+1.
- **Accept to eval start:** a handshake at cycle n gives `o_eval_start`=1 at n+1, with samples valid on `o_eval_base`/`o_eval_test` from n+1 to the finish cycle.
- **Finish to next segment:** `i_eval_finish` at cycle n gives the tally and `o_seg_idx` update visible at n+1, and the next FETCH (`o_sample_ready`=1) at n+1.
- **Finish to done:** last-segment finish at n gives `o_done`=1 at n+1 with final `o_score`; `o_busy`=0 at n+2.
- **Throughput:** per segment = 2 cycles + `evaluate` latency.
- **Simultaneous events:**
  - Abort + finish in the same cycle: abort wins, result discarded.
  - Abort + start in IDLE: start ignored.
  - `i_start` while busy is ignored.
- **Reset mid-song:** asynchronous reset returns to IDLE immediately with all outputs 0.

## Configuration
- **Macro:** `SCORE_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT.
  - If `TIMEOUT` cycles elapse without `i_eval_finish`, the segment is tallied as a miss (streak=0) and `o_timeout` is set.
  - The state advances exactly as on a finish.
  - A finish in the cycle the limit is reached counts as a normal finish.
- **Undefined:** WAIT is held indefinitely and `o_timeout` is tied 0.

## Test plan
- **Full song, all hits:** `SEG_NUM`=4; start; 4 pairs (100,100); `evaluate` model returns result=1 after 256 cycles -> `o_done` one pulse, `o_score`=4, `o_combo`=4, four `o_eval_start` pulses.
- **Mixed results:** pattern 1,1,0,1,1,1 with `SEG_NUM`=6 -> `o_score`=5, `o_combo`=3.
- **Backpressure:** `i_sample_valid` low for 10 cycles in FETCH -> no `o_eval_start`, state holds; the pair is accepted on the first valid cycle and `o_eval_start` follows 1 cycle later with the exact samples (e.g. 0x1234/0xABCD).
- **Abort:**
  - Abort during WAIT of segment 2 -> `o_aborted` pulse, no `o_done`, `o_busy`=0 next cycle.
  - Abort and finish in the same cycle -> score unchanged.
- **Start handling:**
  - Start pulsed while busy -> ignored.
  - Reset asserted mid-WAIT -> all outputs 0 asynchronously.
- **Timeout (macro defined, `TIMEOUT`=64):**
  - Model never finishes segment 0 -> after 64 WAIT cycles `o_timeout`=1, `o_seg_idx`=1, `o_score`=0.
  - Without the macro, the scheduler stays in WAIT.

Source files
------------

// File: rtl/score_scheduler.sv
// score_scheduler: per-song sequencer around the evaluate unit; tallies hits and best streak.
// Optional WAIT-state timeout enabled with `define SCORE_SCHED_TIMEOUT_EN.
module score_scheduler #(
    parameter int SEG_NUM = 16,
    parameter int SCORE_W = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_sample_valid,
    input  logic [15:0]        i_sample_base,
    input  logic [15:0]        i_sample_test,
    output logic               o_sample_ready,
    output logic               o_eval_start,
    output logic [15:0]        o_eval_base,
    output logic [15:0]        o_eval_test,
    input  logic               i_eval_finish,
    input  logic               i_eval_result,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_combo,
    output logic [7:0]         o_seg_idx,
    output logic               o_timeout
);

    localparam logic [SCORE_W-1:0] SAT_MAX  = {SCORE_W{1'b1}};
    localparam logic [7:0]         SEG_LAST = 8'(SEG_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_KICK  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] combo_q, combo_d;
    logic [SCORE_W-1:0] streak_q, streak_d;
    logic [SCORE_W-1:0] streak_inc_s;
    logic [7:0]         seg_q, seg_d;
    logic [15:0]        base_q, base_d;
    logic [15:0]        test_q, test_d;
    logic               timeout_q, timeout_d;
    logic               ready_q, kick_q, busy_q, done_q, aborted_q;
    logic               expire_s;
    logic               abort_s;
    logic               hit_s;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SAT_MAX) ? v : v + SCORE_W'(1);
    endfunction

`ifdef SCORE_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_cnt_q;

    // WAIT-cycle counter; restarts every time WAIT is entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= {TMO_W{1'b0}};
        end else if (state_q != S_WAIT) begin
            tmo_cnt_q <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign expire_s = (state_q == S_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT == 32'sd0);
    assign expire_s         = 1'b0;
`endif

    // Next-state, tally and sample-latch logic
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        combo_d      = combo_q;
        streak_d     = streak_q;
        seg_d        = seg_q;
        base_d       = base_q;
        test_d       = test_q;
        timeout_d    = timeout_q;
        abort_s      = 1'b0;
        streak_inc_s = sat_inc(streak_q);
        hit_s        = i_eval_finish & i_eval_result;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    score_d   = {SCORE_W{1'b0}};
                    combo_d   = {SCORE_W{1'b0}};
                    streak_d  = {SCORE_W{1'b0}};
                    seg_d     = 8'd0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (i_abort) begin
                    abort_s = 1'b1;
                    state_d = S_IDLE;
                end else if (i_sample_valid) begin
                    base_d  = i_sample_base;
                    test_d  = i_sample_test;
                    state_d = S_KICK;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_KICK: begin
                if (i_abort) begin
                    abort_s = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    abort_s = 1'b1;
                    state_d = S_IDLE;
                end else if (i_eval_finish || expire_s) begin
                    // An expiry without a finish is scored as a miss
                    if (hit_s) begin
                        score_d  = sat_inc(score_q);
                        streak_d = streak_inc_s;
                        combo_d  = (streak_inc_s > combo_q) ? streak_inc_s : combo_q;
                    end else begin
                        streak_d  = {SCORE_W{1'b0}};
                        timeout_d = timeout_q | ~i_eval_finish;
                    end
                    if (seg_q == SEG_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        seg_d   = seg_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                abort_s = i_abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, tally and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            score_q   <= {SCORE_W{1'b0}};
            combo_q   <= {SCORE_W{1'b0}};
            streak_q  <= {SCORE_W{1'b0}};
            seg_q     <= 8'd0;
            base_q    <= 16'd0;
            test_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
            streak_q  <= streak_d;
            seg_q     <= seg_d;
            base_q    <= base_d;
            test_q    <= test_d;
            timeout_q <= timeout_d;
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q   <= 1'b0;
            kick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            ready_q   <= (state_d == S_FETCH);
            kick_q    <= (state_d == S_KICK);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            aborted_q <= abort_s;
        end
    end

    assign o_sample_ready = ready_q;
    assign o_eval_start   = kick_q;
    assign o_eval_base    = base_q;
    assign o_eval_test    = test_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_aborted      = aborted_q;
    assign o_score        = score_q;
    assign o_combo        = combo_q;
    assign o_seg_idx      = seg_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_score_scheduler.sv
// Testbench for score_scheduler: directed and randomized songs against a result-list model.
module tb_score_scheduler;

    localparam int SEG_NUM = 6;
    localparam int SCORE_W = 8;
    localparam int TIMEOUT = 64;
    localparam int SMAX    = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_abort = 1'b0;
    logic               i_sample_valid = 1'b0;
    logic [15:0]        i_sample_base = 16'd0;
    logic [15:0]        i_sample_test = 16'd0;
    logic               o_sample_ready;
    logic               o_eval_start;
    logic [15:0]        o_eval_base;
    logic [15:0]        o_eval_test;
    logic               i_eval_finish = 1'b0;
    logic               i_eval_result = 1'b0;
    logic               o_busy;
    logic               o_done;
    logic               o_aborted;
    logic [SCORE_W-1:0] o_score;
    logic [SCORE_W-1:0] o_combo;
    logic [7:0]         o_seg_idx;
    logic               o_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int n_kick   = 0;
    bit res_q[$];

    score_scheduler #(.SEG_NUM(SEG_NUM), .SCORE_W(SCORE_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_sample_valid(i_sample_valid), .i_sample_base(i_sample_base),
        .i_sample_test(i_sample_test), .o_sample_ready(o_sample_ready),
        .o_eval_start(o_eval_start), .o_eval_base(o_eval_base), .o_eval_test(o_eval_test),
        .i_eval_finish(i_eval_finish), .i_eval_result(i_eval_result), .o_busy(o_busy),
        .o_done(o_done), .o_aborted(o_aborted), .o_score(o_score), .o_combo(o_combo),
        .o_seg_idx(o_seg_idx), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_eval_start === 1'b1) n_kick++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_score();
        int s = 0;
        foreach (res_q[i]) s += int'(res_q[i]);
        return (s > SMAX) ? SMAX : s;
    endfunction

    function automatic int m_combo();
        int best = 0;
        int run  = 0;
        foreach (res_q[i]) begin
            run  = res_q[i] ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        return (best > SMAX) ? SMAX : best;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(o_sample_ready), 0);
        chk({tag, "_kick"}, 32'(o_eval_start), 0);
        chk({tag, "_base"}, 32'(o_eval_base), 0);
        chk({tag, "_test"}, 32'(o_eval_test), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_aborted"}, 32'(o_aborted), 0);
        chk({tag, "_score"}, 32'(o_score), 0);
        chk({tag, "_combo"}, 32'(o_combo), 0);
        chk({tag, "_seg"}, 32'(o_seg_idx), 0);
        chk({tag, "_timeout"}, 32'(o_timeout), 0);
    endtask

    task automatic start_song();
        res_q.delete();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_ready", 32'(o_sample_ready), 1);
        chk("start_busy", 32'(o_busy), 1);
        chk("start_score", 32'(o_score), 0);
        chk("start_combo", 32'(o_combo), 0);
        chk("start_seg", 32'(o_seg_idx), 0);
        chk("start_timeout", 32'(o_timeout), 0);
    endtask

    task automatic do_seg(input logic [15:0] b, input logic [15:0] t, input bit r,
                          input int stall, input int lat, input bit kick_fin);
        chk("fetch_ready", 32'(o_sample_ready), 1);
        for (int k = 0; k < stall; k++) begin
            i_sample_base = 16'($urandom);
            tick();
            chk("stall_no_kick", 32'(o_eval_start), 0);
            chk("stall_ready", 32'(o_sample_ready), 1);
        end
        i_sample_valid = 1'b1;
        i_sample_base  = b;
        i_sample_test  = t;
        tick();
        i_sample_valid = 1'b0;
        i_sample_base  = 16'($urandom);
        i_sample_test  = 16'($urandom);
        chk("kick_pulse", 32'(o_eval_start), 1);
        chk("kick_base", 32'(o_eval_base), 32'(b));
        chk("kick_test", 32'(o_eval_test), 32'(t));
        chk("kick_not_ready", 32'(o_sample_ready), 0);
        if (kick_fin) begin
            i_eval_finish = 1'b1;
            i_eval_result = 1'b1;
        end
        tick();
        i_eval_finish = 1'b0;
        chk("kick_one_cycle", 32'(o_eval_start), 0);
        chk("kick_finish_ignored", 32'(o_score), m_score());
        repeat (lat) tick();
        chk("wait_hold_base", 32'(o_eval_base), 32'(b));
        chk("wait_hold_test", 32'(o_eval_test), 32'(t));
        chk("wait_not_ready", 32'(o_sample_ready), 0);
        i_eval_finish = 1'b1;
        i_eval_result = r;
        tick();
        i_eval_finish = 1'b0;
        i_eval_result = 1'b0;
        res_q.push_back(r);
        chk("tally_score", 32'(o_score), m_score());
        chk("tally_combo", 32'(o_combo), m_combo());
        if (res_q.size() == SEG_NUM) begin
            chk("done_pulse", 32'(o_done), 1);
            chk("done_busy", 32'(o_busy), 1);
            tick();
            chk("done_one_cycle", 32'(o_done), 0);
            chk("done_idle", 32'(o_busy), 0);
            chk("done_hold_score", 32'(o_score), m_score());
        end else begin
            chk("next_ready", 32'(o_sample_ready), 1);
            chk("next_seg", 32'(o_seg_idx), res_q.size());
            chk("no_early_done", 32'(o_done), 0);
        end
    endtask

    initial begin
        int  k0;
        bit  plan[6];
        plan = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(o_busy), 0);

        // Directed song: backpressure, finish during KICK, start while busy
        k0 = n_kick;
        start_song();
        for (int s = 0; s < SEG_NUM; s++) begin
            if (s == 3) begin
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
                chk("busy_start_seg", 32'(o_seg_idx), 3);
                chk("busy_start_ready", 32'(o_sample_ready), 1);
                chk("busy_start_score", 32'(o_score), m_score());
            end
            if (s == 0) do_seg(16'h1234, 16'hABCD, plan[s], 10, 40, 1'b1);
            else        do_seg(16'($urandom), 16'($urandom), plan[s], 0, s * 3, 1'b0);
        end
        chk("plan_score", 32'(o_score), 5);
        chk("plan_combo", 32'(o_combo), 3);
        chk("plan_kicks", n_kick - k0, SEG_NUM);

        // Randomized songs
        for (int song = 0; song < 4; song++) begin
            k0 = n_kick;
            start_song();
            for (int s = 0; s < SEG_NUM; s++) begin
                do_seg(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 12), 1'b0);
            end
            chk("rand_kicks", n_kick - k0, SEG_NUM);
        end

        // Abort together with finish during WAIT of segment 2
        start_song();
        do_seg(16'($urandom), 16'($urandom), 1'b1, 0, 2, 1'b0);
        do_seg(16'($urandom), 16'($urandom), 1'b1, 0, 2, 1'b0);
        i_sample_valid = 1'b1;
        tick();
        i_sample_valid = 1'b0;
        repeat (5) tick();
        i_abort       = 1'b1;
        i_eval_finish = 1'b1;
        i_eval_result = 1'b1;
        tick();
        i_abort       = 1'b0;
        i_eval_finish = 1'b0;
        i_eval_result = 1'b0;
        chk("abort_pulse", 32'(o_aborted), 1);
        chk("abort_idle", 32'(o_busy), 0);
        chk("abort_no_done", 32'(o_done), 0);
        chk("abort_score", 32'(o_score), m_score());
        chk("abort_combo", 32'(o_combo), m_combo());
        tick();
        chk("abort_one_cycle", 32'(o_aborted), 0);
        chk("abort_no_done2", 32'(o_done), 0);

        // Abort and start together in IDLE: start ignored, score retained
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("idle_abort_busy", 32'(o_busy), 0);
        chk("idle_abort_ready", 32'(o_sample_ready), 0);
        chk("idle_abort_no_pulse", 32'(o_aborted), 0);
        chk("idle_abort_score", 32'(o_score), m_score());

        // Abort in FETCH with a valid pair: no eval start
        start_song();
        k0 = n_kick;
        i_abort        = 1'b1;
        i_sample_valid = 1'b1;
        tick();
        i_abort        = 1'b0;
        i_sample_valid = 1'b0;
        chk("fetch_abort_pulse", 32'(o_aborted), 1);
        chk("fetch_abort_busy", 32'(o_busy), 0);
        tick();
        tick();
        chk("fetch_abort_no_kick", n_kick - k0, 0);

        // Asynchronous reset in the middle of WAIT
        start_song();
        do_seg(16'($urandom), 16'($urandom), 1'b1, 0, 1, 1'b0);
        i_sample_valid = 1'b1;
        i_sample_base  = 16'h5A5A;
        i_sample_test  = 16'hA5A5;
        tick();
        i_sample_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", 32'(o_busy), 0);

        // Segment whose evaluate never finishes
        start_song();
        i_sample_valid = 1'b1;
        tick();
        i_sample_valid = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("tmo_before_flag", 32'(o_timeout), 0);
        chk("tmo_before_seg", 32'(o_seg_idx), 0);
        tick();
`ifdef SCORE_SCHED_TIMEOUT_EN
        chk("tmo_flag", 32'(o_timeout), 1);
        chk("tmo_seg", 32'(o_seg_idx), 1);
        chk("tmo_score", 32'(o_score), 0);
        chk("tmo_ready", 32'(o_sample_ready), 1);
`else
        repeat (100) tick();
        chk("hold_wait_busy", 32'(o_busy), 1);
        chk("hold_wait_ready", 32'(o_sample_ready), 0);
        chk("hold_wait_seg", 32'(o_seg_idx), 0);
        chk("hold_wait_timeout", 32'(o_timeout), 0);
`endif
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("tmo_abort_idle", 32'(o_busy), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
